lsmitll_sync_pulse_rx: RTL
==========================

// Module: lsmitll_sync_pulse_rx
// PURPOSE
// - Receiving end of a clocked RSFQ cell output (e.g. an Always0/Always1 sync source): samples one
//   pulse/no-pulse bit per clock, deserialises bits into WIDTH-bit words and checks each bit against a
//   constant expected level.
// - Sits in the digital test harness downstream of a synchronous cell model. Flags and counts deviations.
// PARAMETERS
// - WIDTH      8  bits per deserialised word (>=2)
// - EXPECT     0  expected value of every accepted bit (0 or 1)
// - ERR_CNT_W  8  width of the saturating mismatch counter
// PORTS
// - clk            in   1           clock; all state updates on rising edge
// - rst_n          in   1           asynchronous, active-low reset
// - q_in           in   1           1 = pulse arrived in the preceding clock period
// - en             in   1           accept q_in on this edge
// - realign        in   1           discard partial word and restart frame at bit 0
// - clr_err        in   1           synchronous clear of err/err_cnt
// - word           out  WIDTH       last complete word, LSB = first received bit
// - word_valid     out  1           one-cycle strobe, word updated
// - bit_cnt        out  clog2(WIDTH) index of next bit within frame
// - err            out  1           sticky: some accepted bit != EXPECT
// - err_cnt        out  ERR_CNT_W   saturating count of mismatching bits
// - first_err_idx  out  16          (macro only) see CONFIGURATION
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs and internal shift register = 0; takes effect immediately,
//   including mid-frame; first edge after release behaves as frame start.
// - Accept: en=1 at rising edge -> sreg <= {q_in, sreg[WIDTH-1:1]}; bit_cnt++.
// - Frame end: accept with bit_cnt==WIDTH-1 -> word <= {q_in, sreg[WIDTH-1:1]}, bit_cnt <= 0,
//   word_valid=1 for exactly the following cycle. Latency: 1 cycle from the last bit's edge.
// - word holds its value between strobes. word_valid=0 on every non-completing cycle.
// - en=0: no shift, bit_cnt/sreg/word held. Frame resumes on the next accept, with no bit loss.
// - realign=1: bit_cnt <= 0 and sreg <= 0; no word_valid, err state untouched.
//   If en=1 in the same cycle, q_in is taken as bit 0 of the new frame (bit_cnt -> 1).
// - Check: every accepted bit with q_in!=EXPECT sets err and increments err_cnt, saturating at
//   2^ERR_CNT_W-1 (no wrap). Bits on en=0 cycles are not checked.
// - clr_err=1: err, err_cnt cleared. A mismatch in the same cycle counts after the clear
//   (err=1, err_cnt=1).
// - States: implicit FRAME counter 0..WIDTH-1 with wrap; no other FSM. realign and reset are the only
//   ways to leave a frame early.
// CONFIGURATION
// - LSMITLL_RX_FIRST_ERR_EN defined: adds port first_err_idx[15:0] and a 16-bit accepted-bit
//   counter (saturating at 0xFFFF, not cleared by realign).
//   - On the first mismatch since reset/clr_err, first_err_idx latches that bit's absolute index
//     (0-based).
//   - first_err_idx holds until reset or clr_err, which clear it to 0.
//   - clr_err also resets the accepted-bit counter. Same-cycle clr+mismatch latches index 0.
// - Not defined: port and counters absent. All other behaviour identical.
// TESTING
// - Reset: assert rst_n=0 at bit 5 of a frame between edges -> all outputs 0 without a clock edge;
//   after release, 8 accepts give one word_valid.
// - Always0 source: WIDTH=8, en=1, q_in=0 for 16 cycles -> word_valid on cycles 9 and 17, word=0x00,
//   err=0, err_cnt=0.
// - Single pulse: q_in=1 only on accepted bit 11 -> second word=0x08, err=1, err_cnt=1;
//   first_err_idx=11 with macro.
// - Gaps: en=0 for 3 cycles after bit 4 -> word_valid 1 cycle after the 8th accepted edge (12th edge
//   overall); word intact.
// - Realign at bit_cnt=5 with en=1, q_in=1 -> no strobe; next strobe after 7 further accepts,
//   word[0]=1.
// - Saturation: ERR_CNT_W=4, 20 mismatches -> err_cnt=15. Then clr_err with mismatch -> err_cnt=1,
//   err=1.

Source files
------------

// File: rtl/lsmitll_sync_pulse_rx_if.sv
// Handshake/bus bundle for lsmitll_sync_pulse_rx.
// LSMITLL_RX_FIRST_ERR_EN adds first_err_idx.
interface lsmitll_sync_pulse_rx_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    localparam int CW = $clog2(WIDTH);

    logic                 q_in;
    logic                 en;
    logic                 realign;
    logic                 clr_err;
    logic [WIDTH-1:0]     word;
    logic                 word_valid;
    logic [CW-1:0]        bit_cnt;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef LSMITLL_RX_FIRST_ERR_EN
    logic [15:0]          first_err_idx;

    modport master (
        output q_in, en, realign, clr_err,
        input  word, word_valid, bit_cnt, err, err_cnt, first_err_idx
    );
    modport slave (
        input  q_in, en, realign, clr_err,
        output word, word_valid, bit_cnt, err, err_cnt, first_err_idx
    );
`else
    modport master (
        output q_in, en, realign, clr_err,
        input  word, word_valid, bit_cnt, err, err_cnt
    );
    modport slave (
        input  q_in, en, realign, clr_err,
        output word, word_valid, bit_cnt, err, err_cnt
    );
`endif
endinterface

// File: rtl/lsmitll_sync_pulse_rx.sv
// Sync pulse receiver: deserialises q_in into words, checks bits vs EXPECT.
// LSMITLL_RX_FIRST_ERR_EN adds absolute index of the first mismatching bit.
module lsmitll_sync_pulse_rx #(
    parameter int   WIDTH     = 8,
    parameter logic EXPECT    = 1'b0,
    parameter int   ERR_CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    lsmitll_sync_pulse_rx_if.slave rx
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    // sreg holds the WIDTH-1 most recent bits, oldest at bit 0
    logic [WIDTH-2:0]     sreg;
    logic [CW-1:0]        bit_cnt;
    logic [WIDTH-1:0]     word;
    logic                 word_valid;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [WIDTH-1:0]     nxt;
    logic [WIDTH-1:0]     nxt0;
    logic                 mis;

    assign nxt  = {rx.q_in, sreg};
    assign nxt0 = {rx.q_in, {(WIDTH-1){1'b0}}};
    assign mis  = rx.en && (rx.q_in != EXPECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (rx.realign) begin
                if (rx.en) begin
                    sreg    <= nxt0[WIDTH-1:1];
                    bit_cnt <= CW'(1);
                end else begin
                    sreg    <= '0;
                    bit_cnt <= '0;
                end
            end else if (rx.en) begin
                sreg <= nxt[WIDTH-1:1];
                if (bit_cnt == LAST) begin
                    word       <= nxt;
                    word_valid <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    // a mismatch in the clearing cycle counts as the first after the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (rx.clr_err) begin
            err     <= mis;
            err_cnt <= {{(ERR_CNT_W-1){1'b0}}, mis};
        end else if (mis) begin
            err <= 1'b1;
            if (err_cnt != CNT_MAX)
                err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef LSMITLL_RX_FIRST_ERR_EN
    logic [15:0] acc_cnt;
    logic [15:0] first_err_idx;

    // err low means no mismatch has been latched since reset/clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt       <= '0;
            first_err_idx <= '0;
        end else if (rx.clr_err) begin
            acc_cnt       <= {15'b0, rx.en};
            first_err_idx <= '0;
        end else begin
            if (rx.en && acc_cnt != 16'hFFFF)
                acc_cnt <= acc_cnt + 16'd1;
            if (mis && !err)
                first_err_idx <= acc_cnt;
        end
    end

    assign rx.first_err_idx = first_err_idx;
`endif

    assign rx.word       = word;
    assign rx.word_valid = word_valid;
    assign rx.bit_cnt    = bit_cnt;
    assign rx.err        = err;
    assign rx.err_cnt    = err_cnt;
endmodule
